control_unit_pipe: RTL

- Parametrised successor to the single-cycle EX control decoder for the MIPS-subset pipeline (FETCH -> EX -> WB).
- Registers the decoded control word into EX and owns the branch/jump flush FSM.
- Owns the hi/lo multiply-latency interlock: a busy counter plus fetch stall.
- Drives N_GPIO output-enable channels instead of a single GPIO strobe.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/control_decode.sv | 90 +++++++++
 rtl/control_unit_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the EX-stage control unit of the MIPS-subset
// pipeline: opcode/funct encodings, ALU operation codes, the flush/interlock
// FSM state type, the decoded control word and a hi/lo-use classifier.
package ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  // ALU operations
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;

  typedef enum logic [1:0] {RUN, FLUSH, HILO_WAIT} state_t;

  // All-zero value of this struct is the bubble word.
  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic [1:0] regsel;
    logic       enhilo;
    logic       regwrite;
    logic [1:0] alu_src;
    logic       rdrt;
    logic       is_bne;
    logic       is_j;
    logic [4:0] gpio_ch;
    logic       gpio_en;
  } ctrl_word_t;

  // Instructions that read or write hi/lo and so must wait for the multiplier.
  function automatic logic uses_hilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) &&
           ((fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_MFHI) || (fn == FN_MFLO));
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder.
// Ports:
//   instr - 32-bit instruction word
//   word  - decoded control word (all zero for unknown opcode/funct)
module control_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_word_t  word
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;
  logic [4:0] sh;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rd = instr[15:11];
  assign sh = instr[10:6];
  // rs/rt/immediate only matter to the datapath, not to control.
  assign unused_fields = ^instr[25:16];

  always_comb begin
    word = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: begin word.alu_op = ALU_ADD; word.regwrite = 1'b1; end
          FN_SUB, FN_SUBU: begin word.alu_op = ALU_SUB; word.regwrite = 1'b1; end
          FN_AND:          begin word.alu_op = ALU_AND; word.regwrite = 1'b1; end
          FN_OR:           begin word.alu_op = ALU_OR;  word.regwrite = 1'b1; end
          FN_MULT:         begin word.alu_op = ALU_MULT;  word.enhilo = 1'b1; end
          FN_MULTU:        begin word.alu_op = ALU_MULTU; word.enhilo = 1'b1; end
          FN_MFHI:         begin word.regsel = 2'd1; word.regwrite = 1'b1; end
          FN_MFLO:         begin word.regsel = 2'd2; word.regwrite = 1'b1; end
          FN_SLL: begin
            word.alu_op   = ALU_SLL;
            word.shamt    = sh;
            word.regwrite = 1'b1;
          end
          FN_SRA: begin
            word.alu_op   = ALU_SRA;
            word.shamt    = sh;
            word.regwrite = 1'b1;
          end
          FN_SRL: begin
            // srl into $zero is repurposed as a GPIO write; shamt picks the channel.
            if (rd != 5'd0) begin
              word.alu_op   = ALU_SRL;
              word.shamt    = sh;
              word.regwrite = 1'b1;
            end else begin
              word.gpio_ch = sh;
              word.gpio_en = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        word.alu_op   = ALU_ADD;
        word.alu_src  = 2'd1;
        word.rdrt     = 1'b1;
        word.regwrite = 1'b1;
      end
      OP_LUI: begin
        word.alu_op   = ALU_SLL;
        word.shamt    = 5'd16;
        word.alu_src  = 2'd1;
        word.rdrt     = 1'b1;
        word.regwrite = 1'b1;
      end
      OP_ORI: begin
        word.alu_op   = ALU_OR;
        word.alu_src  = 2'd2;
        word.rdrt     = 1'b1;
        word.regwrite = 1'b1;
      end
      OP_BNE: begin
        word.alu_op = ALU_SUB;
        word.is_bne = 1'b1;
      end
      OP_J: word.is_j = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// EX-stage control unit: registers the decoded control word into EX, runs
// the branch/jump flush FSM and the hi/lo multiply-latency interlock, and
// expands GPIO writes into one-hot output enables.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   instr_F, valid_F  - instruction leaving FETCH and its valid flag
//   zero_EX           - ALU zero flag of the instruction in EX
//   *_EX              - registered EX control fields
//   pc_src_EX         - next-PC select (0 pc+4, 1 branch, 2 jump)
//   stall_FETCH       - hold PC and instr_F
//   gpio_we           - one-hot GPIO write strobe
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int N_GPIO     = 1,
  parameter int MULT_LAT   = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_F,
  input  logic              valid_F,
  input  logic              zero_EX,
  output logic [3:0]        alu_op_EX,
  output logic [4:0]        shamt_EX,
  output logic [1:0]        regsel_EX,
  output logic              enhilo_EX,
  output logic              regwrite_EX,
  output logic [1:0]        alu_src_EX,
  output logic              rdrt_EX,
  output logic [1:0]        pc_src_EX,
  output logic              stall_FETCH,
  output logic [N_GPIO-1:0] gpio_we
);

  localparam logic [3:0] LAT_M1 = 4'(MULT_LAT - 1);
  localparam logic [1:0] PEN_M1 = 2'(BR_PENALTY - 1);

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  ctrl_word_t dec_w;
  ctrl_word_t next_w;
  ctrl_word_t ex_word_p0;
  logic       vld_p0;
  state_t     state;
  logic [1:0] flush_cnt;
  logic [3:0] busy_cnt;
  logic       taken;
  logic       hilo_hazard;
  logic       issue;

  control_decode u_decode (
    .instr (instr_F),
    .word  (dec_w)
  );

  assign taken       = vld_p0 && (ex_word_p0.is_j || (ex_word_p0.is_bne && !zero_EX));
  assign hilo_hazard = valid_F && uses_hilo(instr_F[31:26], instr_F[5:0]) && (busy_cnt != 4'd0);

  // A taken branch in EX flushes the instruction in FETCH, so it also
  // masks any hi/lo stall that instruction would otherwise raise.
  always_comb begin
    issue       = 1'b0;
    stall_FETCH = 1'b0;
    case (state)
      RUN: begin
        issue       = valid_F && !taken && !hilo_hazard;
        stall_FETCH = !taken && hilo_hazard;
      end
      FLUSH: stall_FETCH = 1'b1;
      HILO_WAIT: begin
        issue       = valid_F && (busy_cnt == 4'd0);
        stall_FETCH = (busy_cnt != 4'd0);
      end
      default: ;
    endcase
  end

  assign next_w = issue ? dec_w : '0;

  // FETCH -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_word_p0 <= '0;
      vld_p0     <= 1'b0;
      state      <= RUN;
      flush_cnt  <= 2'd0;
      busy_cnt   <= 4'd0;
    end else begin
      ex_word_p0 <= next_w;
      vld_p0     <= issue;

      if (issue && dec_w.enhilo) busy_cnt <= LAT_M1;
      else                       busy_cnt <= sat_dec(busy_cnt);

      case (state)
        RUN: begin
          if (taken) begin
            state     <= FLUSH;
            flush_cnt <= PEN_M1;
          end else if (hilo_hazard) begin
            state <= HILO_WAIT;
          end
        end
        FLUSH: begin
          if (flush_cnt == 2'd0) state <= RUN;
          else                   flush_cnt <= flush_cnt - 2'd1;
        end
        HILO_WAIT: begin
          if (busy_cnt == 4'd0) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign alu_op_EX   = ex_word_p0.alu_op;
  assign shamt_EX    = ex_word_p0.shamt;
  assign regsel_EX   = ex_word_p0.regsel;
  assign enhilo_EX   = ex_word_p0.enhilo;
  assign regwrite_EX = ex_word_p0.regwrite;
  assign alu_src_EX  = ex_word_p0.alu_src;
  assign rdrt_EX     = ex_word_p0.rdrt;

  always_comb begin
    pc_src_EX = 2'd0;
    if (vld_p0 && ex_word_p0.is_j)                        pc_src_EX = 2'd2;
    else if (vld_p0 && ex_word_p0.is_bne && !zero_EX)     pc_src_EX = 2'd1;
  end

  // Channels at or above N_GPIO never match, so out-of-range writes are dropped.
  always_comb begin
    gpio_we = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      if (vld_p0 && ex_word_p0.gpio_en && (ex_word_p0.gpio_ch == 5'(i)))
        gpio_we[i] = 1'b1;
    end
  end

endmodule
